// File: rtl/rca_adder.sv
// Ripple-carry adder with a combinational sum, carry, overflow and per-stage carry view.
// It also provides a one-cycle registered copy of sum, cout and ovf.
`timescale 1ns/1ps
module rca_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  logic [WIDTH-1:0] stage_cin;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  // Full-adder ripple chain; stage_cin keeps each stage's carry-in for the overflow rule.
  always_comb begin : ripple_chain
    logic c;
    c         = cin;
    sum       = {WIDTH{1'b0}};
    carry     = {WIDTH{1'b0}};
    stage_cin = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      stage_cin[i] = c;
      sum[i]       = a[i] ^ b[i] ^ c;
      carry[i]     = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      c            = carry[i];
    end
  end

  // Carry out and signed overflow taken from the MSB stage.
  always_comb begin
    cout = carry[WIDTH-1];
    ovf  = carry[WIDTH-1] ^ stage_cin[WIDTH-1];
  end

  // Next-state for the output registers; reset wins over capture.
  always_comb begin
    sum_d  = {WIDTH{1'b0}};
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    if (rst) begin
      sum_d  = {WIDTH{1'b0}};
      cout_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      sum_d  = sum;
      cout_d = cout;
      ovf_d  = ovf;
    end
  end

  // Output registers, updated every cycle.
  always_ff @(posedge clk) begin
    sum_q  <= sum_d;
    cout_q <= cout_d;
    ovf_q  <= ovf_d;
  end

endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder (WIDTH=4).
// It runs a directed vector table, registered-timing sequences and an exhaustive sweep.
`timescale 1ns/1ps
module tb_rca_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [W-1:0] carry;
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         ovf_q;

  int errors = 0;
  int checks = 0;

  rca_adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf),
    .carry  (carry),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [W-1:0] carry;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vecs[8];

  initial begin
    // Hand-computed vectors: a, b, cin, sum, cout, ovf, carry
    vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0001};
    vecs[2] = '{4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0010};
    vecs[3] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111};
    vecs[4] = '{4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b1111};
    vecs[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 4'b0111};
    vecs[6] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000};
    vecs[7] = '{4'b1100, 4'b1100, 1'b0, 4'b1000, 1'b1, 1'b0, 4'b1100};

    rst = 1'b1;
    a   = 4'b0011;
    b   = 4'b0100;
    cin = 1'b0;

    // Reset held for two edges; combinational path must keep tracking meanwhile.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_sum_q", 32'(sum_q), 32'h0);
    check("rst_cout_q", 32'(cout_q), 32'h0);
    check("rst_ovf_q", 32'(ovf_q), 32'h0);
    check("rst_comb_sum", 32'(sum), 32'h7);

    // Release reset with the wrap-around case: first capture on the first edge after release.
    @(negedge clk);
    rst = 1'b0;
    a   = 4'b1111;
    b   = 4'b0001;
    cin = 1'b0;
    #1;
    check("pre_edge_cout_q", 32'(cout_q), 32'h0);
    @(posedge clk);
    #1;
    check("cap1_sum_q", 32'(sum_q), 32'h0);
    check("cap1_cout_q", 32'(cout_q), 32'h1);
    check("cap1_ovf_q", 32'(ovf_q), 32'h0);

    // Overflow case; the register must still hold the old value before the edge.
    @(negedge clk);
    a = 4'b0111;
    b = 4'b0001;
    #1;
    check("lat_hold_cout_q", 32'(cout_q), 32'h1);
    @(posedge clk);
    #1;
    check("cap2_sum_q", 32'(sum_q), 32'h8);
    check("cap2_cout_q", 32'(cout_q), 32'h0);
    check("cap2_ovf_q", 32'(ovf_q), 32'h1);

    // Load a carry, then reset mid-stream with 0101+0010 presented.
    @(negedge clk);
    a = 4'b1111;
    b = 4'b0001;
    @(posedge clk);
    #1;
    check("cap3_cout_q", 32'(cout_q), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    a   = 4'b0101;
    b   = 4'b0010;
    #1;
    check("midrst_comb_sum", 32'(sum), 32'h7);
    @(posedge clk);
    #1;
    check("midrst_sum_q", 32'(sum_q), 32'h0);
    check("midrst_cout_q", 32'(cout_q), 32'h0);
    check("midrst_ovf_q", 32'(ovf_q), 32'h0);

    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      a   = vecs[i].a;
      b   = vecs[i].b;
      cin = vecs[i].cin;
      #1;
      check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].carry));
    end

    // Exhaustive sweep against arithmetic and the sign rule.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          int           total;
          logic [W-1:0] es;
          logic         eo;
          a     = 4'(ia);
          b     = 4'(ib);
          cin   = 1'(ic);
          total = ia + ib + ic;
          es    = 4'(total);
          eo    = (a[3] == b[3]) && (es[3] != a[3]);
          #1;
          check($sformatf("sweep_%0d_%0d_%0d_sum", ia, ib, ic), 32'({cout, sum}), 32'(total));
          check($sformatf("sweep_%0d_%0d_%0d_ovf", ia, ib, ic), 32'(ovf), 32'(eo));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
